cola_change_out: RTL and testbench

Change-return dispenser for the cola vending machine: the payout side, paired with the coin-in FSM that counts 1-cent inputs.
- Takes a one-cycle refund request carrying an amount in cents.
- Drives fixed-width eject pulses to the 5-cent and 1-cent coin tubes until the amount is paid, then signals completion.
- Uses 5-cent coins first and falls back to 1-cent coins when the 5-cent tube reports empty.

---
 rtl/cola_pkg.sv | 26 ++
 rtl/cola_pulse_timer.sv | 36 +++
 rtl/cola_change_out.sv | 142 ++++++++++++++
 tb/tb_cola_change_out.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cola_pkg.sv
// ---------------------------------------------------------------------------
// cola_pkg
//
// Shared definitions for the cola vending machine coin path.
//   - state_t : payout FSM state encoding (ST_IDLE .. ST_FIN)
//   - CENT_1, CENT_5 : coin values in cents, also used by the coin-in FSM
//   - isBusy() : true for every state other than ST_IDLE
// ---------------------------------------------------------------------------
package cola_pkg;

    localparam int CENT_1 = 1;
    localparam int CENT_5 = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    function automatic logic isBusy(input state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/cola_pulse_timer.sv
// ---------------------------------------------------------------------------
// cola_pulse_timer
//
// 4-bit down-counter that times both the eject pulse and the gap after it.
//
// Ports:
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset, clears the count
//   load_i     : load strobe, takes priority over counting
//   load_val_i : value loaded when load_i is high
//   expired_o  : high while the count is zero
// ---------------------------------------------------------------------------
module cola_pulse_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic       expired_o
);

    logic [3:0] cnt_q;

    // The count parks at zero so an unloaded timer reads as expired.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign expired_o = (cnt_q == 4'd0);

endmodule

// File: rtl/cola_change_out.sv
// ---------------------------------------------------------------------------
// cola_change_out
//
// Change-return dispenser. A one-cycle refund request with an amount in
// cents is paid out as fixed-width eject pulses, 5-cent coins first and
// 1-cent coins when the 5-cent tube is empty or the remainder is too small.
// A one-cycle DONE strobe ends every accepted request.
//
// Ports:
//   CLK      : clock
//   RST      : asynchronous active-high reset, abandons any refund
//   REQ      : refund request, only honoured while idle
//   AMT      : refund amount in cents, valid with REQ
//   EMPTY5   : 5-cent tube empty, looked at once per coin
//   COIN5OUT : 5-cent eject pulse
//   COIN1OUT : 1-cent eject pulse
//   BUSY     : high whenever a refund is in progress
//   DONE     : one-cycle completion strobe
// ---------------------------------------------------------------------------
module cola_change_out
    import cola_pkg::*;
#(
    parameter int AMT_W     = 4,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 2,
    parameter int BIG_COIN  = CENT_5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    input  logic [AMT_W-1:0] AMT,
    input  logic             EMPTY5,
    output logic             COIN5OUT,
    output logic             COIN1OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [AMT_W-1:0] BIG_V      = AMT_W'(BIG_COIN);
    localparam logic [AMT_W-1:0] SMALL_V    = AMT_W'(CENT_1);
    localparam logic [3:0]       PULSE_LOAD = 4'(PULSE_LEN - 1);
    localparam logic [3:0]       GAP_LOAD   = 4'(GAP_LEN - 1);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             coinSel_q, coinSel_d;
    logic             tmrLoad;
    logic [3:0]       tmrLoadVal;
    logic             tmrExpired;
    logic             coin5_q, coin1_q, busy_q, done_q;

    cola_pulse_timer u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmrLoad),
        .load_val_i (tmrLoadVal),
        .expired_o  (tmrExpired)
    );

    // Next-state logic. The timer is loaded on the way into each timed
    // phase so that its first cycle in PULSE or GAP already holds LEN-1.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        coinSel_d  = coinSel_q;
        tmrLoad    = 1'b0;
        tmrLoadVal = 4'd0;
        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    if (AMT != '0) begin
                        rem_d   = AMT;
                        state_d = ST_SEL;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_SEL: begin
                // The coin chosen here never exceeds the remainder, so
                // the subtraction cannot wrap.
                if ((rem_q >= BIG_V) && !EMPTY5) begin
                    coinSel_d = 1'b1;
                    rem_d     = rem_q - BIG_V;
                end else begin
                    coinSel_d = 1'b0;
                    rem_d     = rem_q - SMALL_V;
                end
                tmrLoad    = 1'b1;
                tmrLoadVal = PULSE_LOAD;
                state_d    = ST_PULSE;
            end
            ST_PULSE: begin
                if (tmrExpired) begin
                    tmrLoad    = 1'b1;
                    tmrLoadVal = GAP_LOAD;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmrExpired) begin
                    state_d = (rem_q == '0) ? ST_FIN : ST_SEL;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so each one equals a
    // decode of the current registered state and no input reaches a pin
    // combinationally. Reset clears them at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            coinSel_q <= 1'b0;
            coin5_q   <= 1'b0;
            coin1_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            coinSel_q <= coinSel_d;
            coin5_q   <= (state_d == ST_PULSE) && coinSel_d;
            coin1_q   <= (state_d == ST_PULSE) && !coinSel_d;
            busy_q    <= isBusy(state_d);
            done_q    <= (state_d == ST_FIN);
        end
    end

    assign COIN5OUT = coin5_q;
    assign COIN1OUT = coin1_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_cola_change_out.sv
// ---------------------------------------------------------------------------
// tb_cola_change_out
//
// Directed bench for the change-return dispenser. Each refund pushes its
// expected per-cycle output vector {BUSY, COIN5OUT, COIN1OUT, DONE} onto a
// scoreboard queue; every cycle one entry is popped and compared.
// ---------------------------------------------------------------------------
module tb_cola_change_out;

    localparam int AMT_W     = 4;
    localparam int PULSE_LEN = 2;
    localparam int GAP_LEN   = 2;

    typedef struct packed {
        logic busy;
        logic c5;
        logic c1;
        logic done;
    } outv_t;

    logic             CLK;
    logic             RST;
    logic             REQ;
    logic [AMT_W-1:0] AMT;
    logic             EMPTY5;
    logic             COIN5OUT;
    logic             COIN1OUT;
    logic             BUSY;
    logic             DONE;

    int    errors;
    int    checks;
    outv_t sb[$];

    cola_change_out #(
        .AMT_W     (AMT_W),
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN),
        .BIG_COIN  (5)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .AMT      (AMT),
        .EMPTY5   (EMPTY5),
        .COIN5OUT (COIN5OUT),
        .COIN1OUT (COIN1OUT),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected timeline after a request in cycle 0: per coin one select
    // cycle, PULSE_LEN eject cycles and GAP_LEN quiet cycles, then one
    // DONE cycle and one idle cycle. bigMask bit i marks coin i as 5 cents.
    task automatic pushTimeline(input int nCoins, input logic [15:0] bigMask);
        for (int i = 0; i < nCoins; i++) begin
            sb.push_back('{busy: 1'b1, c5: 1'b0, c1: 1'b0, done: 1'b0});
            for (int p = 0; p < PULSE_LEN; p++)
                sb.push_back('{busy: 1'b1, c5: bigMask[i], c1: !bigMask[i], done: 1'b0});
            for (int g = 0; g < GAP_LEN; g++)
                sb.push_back('{busy: 1'b1, c5: 1'b0, c1: 1'b0, done: 1'b0});
        end
        sb.push_back('{busy: 1'b1, c5: 1'b0, c1: 1'b0, done: 1'b1});
        sb.push_back('{busy: 1'b0, c5: 1'b0, c1: 1'b0, done: 1'b0});
    endtask

    task automatic pushIdle(input int n);
        for (int i = 0; i < n; i++)
            sb.push_back('{busy: 1'b0, c5: 1'b0, c1: 1'b0, done: 1'b0});
    endtask

    // Drives a one-cycle request on the falling edge (cycle 0).
    task automatic applyStimulus(input logic [AMT_W-1:0] amt);
        @(negedge CLK);
        REQ = 1'b1;
        AMT = amt;
    endtask

    // One cycle: drop REQ, sample on the falling edge, compare with the
    // oldest scoreboard entry.
    task automatic checkOutput(input string tag);
        outv_t obs;
        outv_t exp;
        @(negedge CLK);
        REQ = 1'b0;
        obs = '{busy: BUSY, c5: COIN5OUT, c1: COIN1OUT, done: DONE};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("[TB] FAIL %s scoreboard underrun, observed=%b", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("[TB] FAIL %s observed=%b expected=%b (busy,c5,c1,done)", tag, obs, exp);
            end
        end
    endtask

    // Bounded by the queue length pushed for the current refund.
    task automatic drain(input string tag);
        while (sb.size() > 0) checkOutput(tag);
    endtask

    initial begin
        outv_t obs;
        errors = 0;
        checks = 0;
        RST    = 1'b1;
        REQ    = 1'b0;
        AMT    = '0;
        EMPTY5 = 1'b0;

        #2;
        obs = '{busy: BUSY, c5: COIN5OUT, c1: COIN1OUT, done: DONE};
        checks++;
        assert (obs === 4'b0000) else begin
            errors++;
            $error("[TB] FAIL reset observed=%b expected=0000", obs);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        pushIdle(2);
        drain("idle");

        $display("[TB] amt=7 with 5-cent tube stocked");
        applyStimulus(4'd7);
        pushTimeline(3, 16'b001);
        drain("amt7");

        $display("[TB] amt=6 with 5-cent tube empty");
        EMPTY5 = 1'b1;
        applyStimulus(4'd6);
        pushTimeline(6, 16'b0);
        drain("amt6_empty");

        $display("[TB] amt=10, tube empties during first gap");
        EMPTY5 = 1'b0;
        applyStimulus(4'd10);
        pushTimeline(6, 16'b1);
        repeat (4) checkOutput("amt10");
        EMPTY5 = 1'b1;
        drain("amt10");
        EMPTY5 = 1'b0;

        $display("[TB] amt=0");
        applyStimulus(4'd0);
        pushTimeline(0, 16'b0);
        drain("amt0");

        $display("[TB] amt=4, below the large coin");
        applyStimulus(4'd4);
        pushTimeline(4, 16'b0);
        drain("amt4");

        $display("[TB] amt=15, maximum refund");
        applyStimulus(4'd15);
        pushTimeline(3, 16'b111);
        drain("amt15");

        $display("[TB] amt=5 with second request while busy");
        applyStimulus(4'd5);
        pushTimeline(1, 16'b1);
        repeat (2) checkOutput("busyreq");
        REQ = 1'b1;
        AMT = 4'd3;
        drain("busyreq");
        pushIdle(3);
        drain("busyreq_after");

        $display("[TB] reset during pulse of amt=9");
        applyStimulus(4'd9);
        pushTimeline(2, 16'b01);
        repeat (2) checkOutput("rst_pre");
        #1;
        RST = 1'b1;
        #1;
        obs = '{busy: BUSY, c5: COIN5OUT, c1: COIN1OUT, done: DONE};
        checks++;
        assert (obs === 4'b0000) else begin
            errors++;
            $error("[TB] FAIL rst_async observed=%b expected=0000", obs);
        end
        sb.delete();
        pushIdle(3);
        drain("rst_hold");
        RST = 1'b0;
        pushIdle(3);
        drain("rst_after");

        applyStimulus(4'd1);
        pushTimeline(1, 16'b0);
        drain("amt1_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
